iter_divider: RTL

ITER_DIVIDER -- requirements
Module: iter_divider

---
 rtl/iter_divider.sv | 136 +++++++++++++
 1 files changed

// File: rtl/iter_divider.sv
// Iterative 32-bit radix-2 restoring divider for the E-stage DIV/DIVU path.
// Fixed 32-cycle calculation followed by a single-cycle DONE pulse; cancel and reset abort.
module iter_divider (
    input  logic        clk,
    input  logic        reset,
    input  logic        div,
    input  logic        div_signed,
    input  logic [31:0] div_op_a,
    input  logic [31:0] div_op_b,
    input  logic        cancel,
    output logic        div_complete,
    output logic        div_busy,
    output logic [31:0] div_lo,
    output logic [31:0] div_hi
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_next;
    logic [4:0]  count;
    logic [31:0] rem;       // partial remainder; its 33rd bit only exists during a step
    logic [31:0] quo;       // dividend magnitude shifts out as quotient bits shift in
    logic [31:0] b_mag;
    logic [31:0] a_lat;
    logic        neg_q;
    logic        neg_r;
    logic        b_zero;

    logic        start;
    logic        step_en;
    logic        last_step;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic        fits;
    logic [31:0] rem_step;
    logic [31:0] quo_step;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    assign start     = (state == IDLE) && div && !cancel;
    assign step_en   = (state == CALC) && !cancel;
    assign last_step = step_en && (count == 5'd31);

    assign a_neg = div_signed && div_op_a[31];
    assign b_neg = div_signed && div_op_b[31];
    assign a_abs = a_neg ? (32'd0 - div_op_a) : div_op_a;
    assign b_abs = b_neg ? (32'd0 - div_op_b) : div_op_b;

    // A borrow out of bit 32 means the shifted remainder is smaller than the divisor.
    assign shifted  = {rem, quo[31]};
    assign diff     = shifted - {1'b0, b_mag};
    assign fits     = !diff[32];
    assign rem_step = fits ? diff[31:0] : shifted[31:0];
    assign quo_step = {quo[30:0], fits};

    assign q_fix = neg_q ? (32'd0 - quo_step) : quo_step;
    assign r_fix = neg_r ? (32'd0 - rem_step) : rem_step;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next   = state;
        div_complete = 1'b0;
        div_busy     = 1'b0;
        case (state)
            IDLE: begin
                if (div && !cancel) state_next = CALC;
            end
            CALC: begin
                div_busy = 1'b1;
                if (cancel)                 state_next = IDLE;
                else if (count == 5'd31)    state_next = DONE;
            end
            DONE: begin
                div_busy     = 1'b1;
                div_complete = !cancel;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the datapath is reset too, so outputs read as zero straight out of
    // reset and nothing from an aborted operation can leak later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            rem    <= '0;
            quo    <= '0;
            b_mag  <= '0;
            a_lat  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            div_lo <= '0;
            div_hi <= '0;
        end else if (start) begin
            count  <= '0;
            rem    <= '0;
            quo    <= a_abs;
            b_mag  <= b_abs;
            a_lat  <= div_op_a;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            b_zero <= (div_op_b == 32'd0);
        end else if (step_en) begin
            count <= count + 5'd1;
            rem   <= rem_step;
            quo   <= quo_step;
            if (last_step) begin
                if (b_zero) begin
                    div_lo <= 32'hFFFF_FFFF;
                    div_hi <= a_lat;
                end else begin
                    div_lo <= q_fix;
                    div_hi <= r_fix;
                end
            end
        end
    end

endmodule
